// File: rtl/stack_sequencer.sv
// Stack pointer owner and RAM access sequencer for PUSH, POP, CALL and RET.
// One RAM byte per cycle; SP moves with each access so a reset mid-operation leaves SP consistent with RAM.
module stack_sequencer #(
    parameter logic [7:0] SP_RESET = 8'h07,
    parameter logic [7:0] SP_MAX   = 8'h7F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  push_data,
    input  logic [15:0] pc_in,
    input  logic        sp_wr_en,
    input  logic [7:0]  sp_wr_data,
    input  logic [7:0]  ram_rd_byte,
    output logic        ram_wr_en_data,
    output logic [7:0]  ram_wr_addr,
    output logic [7:0]  ram_wr_byte,
    output logic        ram_rd_en_data,
    output logic [7:0]  ram_rd_addr,
    output logic [7:0]  sp,
    output logic [7:0]  pop_data,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        stack_empty,
    output logic        stack_full
);

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_RD_HI,
        S_RD_LO,
        S_FIN
    } state_t;

    localparam logic [7:0] PUSH_LIMIT = SP_MAX - 8'd1;
    localparam logic [7:0] CALL_LIMIT = SP_MAX - 8'd2;
    localparam logic [7:0] POP_LIMIT  = SP_RESET + 8'd1;
    localparam logic [7:0] RET_LIMIT  = SP_RESET + 8'd2;

    state_t      r_state;
    state_t      w_next_state;
    op_t         r_op;
    op_t         w_op;
    logic [7:0]  r_sp;
    logic [7:0]  r_push_data;
    logic [15:0] r_pc_in;
    logic [7:0]  r_pop_data;
    logic [15:0] r_pc_out;
    logic        r_err;
    logic        w_accept;
    logic        w_legal;

    assign w_op = op_t'(op);

    // An SP write in IDLE wins; the requester holds start and is taken next cycle.
    assign w_accept = (r_state == S_IDLE) && !sp_wr_en && start;

    // Checked against the raw SP, so an out-of-range SFR write is judged as-is.
    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_PUSH: w_legal = (r_sp <= PUSH_LIMIT);
            OP_CALL: w_legal = (r_sp <= CALL_LIMIT);
            OP_POP:  w_legal = (r_sp >= POP_LIMIT);
            OP_RET:  w_legal = (r_sp >= RET_LIMIT);
            default: w_legal = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state   = r_state;
        ram_wr_en_data = 1'b0;
        ram_wr_addr    = 8'h00;
        ram_wr_byte    = 8'h00;
        ram_rd_en_data = 1'b0;
        ram_rd_addr    = 8'h00;
        busy           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next_state = S_FIN;
                    end else begin
                        case (w_op)
                            OP_PUSH, OP_CALL: w_next_state = S_WR_LO;
                            OP_POP:           w_next_state = S_RD_LO;
                            default:          w_next_state = S_RD_HI;
                        endcase
                    end
                end
            end
            S_WR_LO: begin
                busy           = 1'b1;
                ram_wr_en_data = 1'b1;
                ram_wr_addr    = r_sp + 8'd1;
                ram_wr_byte    = (r_op == OP_CALL) ? r_pc_in[7:0] : r_push_data;
                w_next_state   = (r_op == OP_CALL) ? S_WR_HI : S_FIN;
            end
            S_WR_HI: begin
                busy           = 1'b1;
                ram_wr_en_data = 1'b1;
                ram_wr_addr    = r_sp + 8'd1;
                ram_wr_byte    = r_pc_in[15:8];
                w_next_state   = S_FIN;
            end
            S_RD_HI: begin
                busy           = 1'b1;
                ram_rd_en_data = 1'b1;
                ram_rd_addr    = r_sp;
                w_next_state   = S_RD_LO;
            end
            S_RD_LO: begin
                busy           = 1'b1;
                ram_rd_en_data = 1'b1;
                ram_rd_addr    = r_sp;
                w_next_state   = S_FIN;
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sp        <= SP_RESET;
            r_op        <= OP_PUSH;
            r_push_data <= 8'h00;
            r_pc_in     <= 16'h0000;
            r_pop_data  <= 8'h00;
            r_pc_out    <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (sp_wr_en) begin
                        r_sp <= sp_wr_data;
                    end else if (start) begin
                        r_op        <= w_op;
                        r_push_data <= push_data;
                        r_pc_in     <= pc_in;
                        r_err       <= !w_legal;
                    end
                end
                S_WR_LO, S_WR_HI: begin
                    r_sp <= r_sp + 8'd1;
                end
                S_RD_HI: begin
                    r_pc_out[15:8] <= ram_rd_byte;
                    r_sp           <= r_sp - 8'd1;
                end
                S_RD_LO: begin
                    if (r_op == OP_POP) begin
                        r_pop_data <= ram_rd_byte;
                    end else begin
                        r_pc_out[7:0] <= ram_rd_byte;
                    end
                    r_sp <= r_sp - 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sp          = r_sp;
    assign pop_data    = r_pop_data;
    assign pc_out      = r_pc_out;
    assign done        = (r_state == S_FIN);
    assign err         = (r_state == S_FIN) && r_err;
    assign stack_empty = (r_sp == SP_RESET);
    assign stack_full  = (r_sp == SP_MAX);

endmodule
